// File: rtl/fpu_fround_pkg.sv
// Shared FPU constants, flag positions and rounding-stage types.
package fpu_fround_pkg;

  localparam logic [31:0]        FP32_QNAN   = 32'h7FBFFFFF;
  localparam logic [31:0]        FP32_MAXFIN = 32'h7F7FFFFF;
  localparam logic [31:0]        FP32_INF    = 32'h7F800000;
  localparam logic signed [11:0] FP32_BIAS   = 12'sd127;

  // FPSCR cause-field bit positions within o_flags
  localparam int unsigned FLAG_V = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_U = 1;
  localparam int unsigned FLAG_I = 0;

  // FPSCR.RM encodings
  typedef enum logic {
    RM_RN = 1'b0,
    RM_RZ = 1'b1
  } rm_e;

  // Result class decided in S1, consumed by the S2 packer
  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO,
    CLS_OVF,
    CLS_FLUSH,
    CLS_FIN
  } cls_e;

endpackage

// File: rtl/fpu_rsh.sv
// Residual-collecting right shifter: shifted data plus OR of all bits lost.
module fpu_rsh #(
  parameter int WIDTH  = 25,
  parameter int SWIDTH = 12
) (
  input  logic [WIDTH-1:0]  data_in,
  input  logic [SWIDTH-1:0] shamt,
  output logic [WIDTH-1:0]  data_out,
  output logic              sticky
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] lost_mask;

  // Shift amounts >= WIDTH clear the data and fold everything into sticky
  always_comb begin
    ones      = '1;
    lost_mask = ~(ones << shamt);
    data_out  = data_in >> shamt;
    sticky    = |(data_in & lost_mask);
  end

endmodule

// File: rtl/fpu_fround.sv
// Round-and-pack stage: unpacked FPU result -> IEEE-754 binary32 + FPSCR flags.
module fpu_fround #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rm,
  input  logic             dn,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_sign,
  input  logic [10:0]      i_exp,
  input  logic [24:0]      i_frac,
  input  logic             i_is_zero,
  input  logic             i_is_inf,
  input  logic             i_is_nan,
  input  logic             i_invalid,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_result,
  output logic [4:0]       o_flags
);

  import fpu_fround_pkg::*;

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s2_load;
  logic s1_advance;
  logic s1_load;

  assign s2_load    = !o_valid || o_ready;
  assign s1_advance = s1_valid && s2_load;
  assign i_ready    = !s1_valid || s1_advance;
  assign s1_load    = i_valid && i_ready;

  // ---------------- S1 combinational ----------------
  logic signed [11:0] be;
  logic signed [11:0] sh_raw;
  logic [11:0]        sh_amt;
  logic               tiny;
  logic               ovf;
  logic [24:0]        sh_data;
  logic               sh_sticky;

  assign be     = $signed({i_exp[10], i_exp}) + FP32_BIAS;
  assign tiny   = (be <= 12'sd0);
  assign ovf    = (be >= 12'sd255);
  assign sh_raw = 12'sd1 - be;
  assign sh_amt = !tiny ? 12'd0 : ((sh_raw > 12'sd26) ? 12'd26 : sh_raw);

  fpu_rsh #(
    .WIDTH  (25),
    .SWIDTH (12)
  ) u_rsh (
    .data_in  ({1'b1, i_frac[24:1]}),
    .shamt    (sh_amt),
    .data_out (sh_data),
    .sticky   (sh_sticky)
  );

  cls_e        c_cls;
  logic [7:0]  c_e8;
  logic [22:0] c_m23;
  logic        c_lsb;
  logic        c_g;
  logic        c_s;
  logic        c_tiny;
  logic        c_rup;
  logic        c_inexact;

  // Classify the input and pick the mantissa/guard/sticky set to round.
  // The subnormal path reuses the normal packer: its exponent field is the
  // surviving hidden bit (always 0 after a shift >= 1), and a round carry out
  // of the 23-bit field then lands in the exponent as 1.
  always_comb begin
    c_cls  = CLS_FIN;
    c_e8   = be[7:0];
    c_m23  = i_frac[24:2];
    c_lsb  = i_frac[2];
    c_g    = i_frac[1];
    c_s    = i_frac[0];
    c_tiny = 1'b0;
    if (i_is_nan) begin
      c_cls = CLS_NAN;
    end else if (i_is_inf) begin
      c_cls = CLS_INF;
    end else if (i_is_zero) begin
      c_cls = CLS_ZERO;
    end else if (ovf) begin
      c_cls = CLS_OVF;
    end else if (tiny) begin
      if (dn) begin
        c_cls = CLS_FLUSH;
      end else begin
        c_e8   = {7'd0, sh_data[24]};
        c_m23  = sh_data[23:1];
        c_lsb  = sh_data[1];
        c_g    = sh_data[0];
        c_s    = sh_sticky | i_frac[0];
        c_tiny = 1'b1;
      end
    end
    c_rup     = (rm_e'(rm) == RM_RN) && c_g && (c_s || c_lsb);
    c_inexact = c_g | c_s;
  end

  // ---------------- S1 register ----------------
  logic [TAG_W-1:0] s1_tag;
  logic             s1_sign;
  cls_e             s1_cls;
  rm_e              s1_rm;
  logic [7:0]       s1_e8;
  logic [22:0]      s1_m23;
  logic             s1_rup;
  logic             s1_inexact;
  logic             s1_tiny;
  logic             s1_inv;

  // S1: capture classification and round decision; rm/dn are frozen here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      s1_sign    <= 1'b0;
      s1_cls     <= CLS_ZERO;
      s1_rm      <= RM_RN;
      s1_e8      <= '0;
      s1_m23     <= '0;
      s1_rup     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_tiny    <= 1'b0;
      s1_inv     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid   <= 1'b1;
        s1_tag     <= i_tag;
        s1_sign    <= i_sign;
        s1_cls     <= c_cls;
        s1_rm      <= rm_e'(rm);
        s1_e8      <= c_e8;
        s1_m23     <= c_m23;
        s1_rup     <= c_rup;
        s1_inexact <= c_inexact;
        s1_tiny    <= c_tiny;
        s1_inv     <= i_invalid;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------- S2 combinational ----------------
  logic [30:0] sum;
  logic [31:0] ovf_word;
  logic [31:0] p_res;
  logic [4:0]  p_flg;

  assign sum      = {s1_e8, s1_m23} + 31'(s1_rup);
  assign ovf_word = (s1_rm == RM_RN) ? {s1_sign, FP32_INF[30:0]}
                                     : {s1_sign, FP32_MAXFIN[30:0]};

  // Increment, post-round overflow check, pack and flag generation
  always_comb begin
    p_res         = {s1_sign, 31'd0};
    p_flg         = '0;
    p_flg[FLAG_V] = s1_inv;
    p_flg[FLAG_Z] = 1'b0;
    case (s1_cls)
      CLS_NAN:  p_res = FP32_QNAN;
      CLS_INF:  p_res = {s1_sign, FP32_INF[30:0]};
      CLS_ZERO: p_res = {s1_sign, 31'd0};
      CLS_OVF: begin
        p_res         = ovf_word;
        p_flg[FLAG_O] = 1'b1;
        p_flg[FLAG_I] = 1'b1;
      end
      CLS_FLUSH: begin
        p_res         = {s1_sign, 31'd0};
        p_flg[FLAG_U] = 1'b1;
        p_flg[FLAG_I] = 1'b1;
      end
      default: begin
        if (sum[30:23] == 8'hFF) begin
          p_res         = ovf_word;
          p_flg[FLAG_O] = 1'b1;
          p_flg[FLAG_I] = 1'b1;
        end else begin
          p_res         = {s1_sign, sum};
          p_flg[FLAG_U] = s1_tiny & s1_inexact;
          p_flg[FLAG_I] = s1_inexact;
        end
      end
    endcase
  end

  // S2: output register, holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_tag    <= '0;
      o_result <= '0;
      o_flags  <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_tag    <= s1_tag;
        o_result <= p_res;
        o_flags  <= p_flg;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fround.sv
// Randomised scoreboard bench for the round-and-pack stage.
module tb_fpu_fround;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             rm;
  logic             dn;
  logic             i_valid;
  logic             i_ready;
  logic [TAG_W-1:0] i_tag;
  logic             i_sign;
  logic [10:0]      i_exp;
  logic [24:0]      i_frac;
  logic             i_is_zero;
  logic             i_is_inf;
  logic             i_is_nan;
  logic             i_invalid;
  logic             o_valid;
  logic             o_ready;
  logic [TAG_W-1:0] o_tag;
  logic [31:0]      o_result;
  logic [4:0]       o_flags;

  fpu_fround #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rm        (rm),
    .dn        (dn),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_tag     (i_tag),
    .i_sign    (i_sign),
    .i_exp     (i_exp),
    .i_frac    (i_frac),
    .i_is_zero (i_is_zero),
    .i_is_inf  (i_is_inf),
    .i_is_nan  (i_is_nan),
    .i_invalid (i_invalid),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_tag     (o_tag),
    .o_result  (o_result),
    .o_flags   (o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    int          exp;
    logic [24:0] frac;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        inv;
    logic        rm;
    logic        dn;
  } stim_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [4:0]       flg;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [TAG_W-1:0] ntag = '0;
  bit               rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: value = sig * 2^(exp-25) with sig = {1,frac}; quantise to the
  // binary32 grid (ulp 2^(max(exp,-126)-23)) and round with integer maths.
  function automatic logic [36:0] ref_model(input stim_t s);
    logic [31:0] r;
    logic [4:0]  f;
    longint      sig, q, rem, half;
    int          e, sh;
    bit          up, inexact, is_tiny;
    f       = {s.inv, 4'b0000};
    is_tiny = (s.exp < -126);
    if (s.nan)               r = 32'h7FBFFFFF;
    else if (s.inf)          r = {s.sign, 31'h7F800000};
    else if (s.zero)         r = {s.sign, 31'h0};
    else if (is_tiny && s.dn) begin
      r    = {s.sign, 31'h0};
      f[1] = 1'b1;
      f[0] = 1'b1;
    end else begin
      sig = (longint'(1) << 25) + longint'(s.frac);
      e   = is_tiny ? -126 : s.exp;
      sh  = e - s.exp + 2;
      if (sh > 40) begin
        q   = 0;
        rem = sig;
        up  = 1'b0;
      end else begin
        q    = sig >> sh;
        rem  = sig - (q << sh);
        half = longint'(1) << (sh - 1);
        up   = !s.rm && ((rem > half) || (rem == half && q[0]));
      end
      inexact = (rem != 0);
      q = q + (up ? 1 : 0);
      if (q >= (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e + 127 >= 255) begin
        r    = s.rm ? {s.sign, 31'h7F7FFFFF} : {s.sign, 31'h7F800000};
        f[2] = 1'b1;
        f[0] = 1'b1;
      end else begin
        if (q < (longint'(1) << 23)) r = {s.sign, 8'd0, q[22:0]};
        else                         r = {s.sign, 8'(e + 127), q[22:0]};
        f[0] = inexact;
        f[1] = is_tiny && inexact;
      end
    end
    return {f, r};
  endfunction

  // Issue one input, holding it until accepted; expectation queued on acceptance
  task automatic send(input stim_t s, input bit use_model,
                      input logic [31:0] xr, input logic [4:0] xf);
    logic [36:0] m;
    int          n;
    bit          done;
    n = 0;
    done = 1'b0;
    i_sign = s.sign; i_exp = 11'(s.exp); i_frac = s.frac;
    i_is_zero = s.zero; i_is_inf = s.inf; i_is_nan = s.nan; i_invalid = s.inv;
    rm = s.rm; dn = s.dn; i_tag = ntag; i_valid = 1'b1;
    while (!done) begin
      if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i_ready) begin
        if (use_model) begin
          m  = ref_model(s);
          xr = m[31:0];
          xf = m[36:32];
        end
        sb.push_back('{tag: ntag, res: xr, flg: xf});
        ntag = ntag + 1'b1;
        done = 1'b1;
      end else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: i_ready stuck at %b, expected 1", i_ready);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    rm      = 1'($urandom);
    dn      = 1'($urandom);
    i_frac  = 25'($urandom);
    i_sign  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_valid = 1'b0;
      rm      = 1'($urandom);
      dn      = 1'($urandom);
      if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic stim_t mk(input logic sg, input int ex, input logic [24:0] fr,
                               input logic r, input logic d);
    stim_t s;
    s = '{sign: sg, exp: ex, frac: fr, zero: 1'b0, inf: 1'b0, nan: 1'b0,
          inv: 1'b0, rm: r, dn: d};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    k;
    s = mk(1'($urandom), 0, 25'($urandom), 1'($urandom), 1'($urandom));
    s.inv = ($urandom_range(0, 7) == 0);
    k = int'($urandom_range(0, 9));
    if (k <= 3) s.exp = int'($urandom_range(0, 20)) - 10;
    else if (k <= 5) begin
      s.exp = int'($urandom_range(0, 20)) + 120;
      if ($urandom_range(0, 3) == 0) s.frac[24:2] = '1;
    end else if (k <= 7) s.exp = -int'($urandom_range(0, 40)) - 115;
    else if (k == 8) s.exp = int'($urandom_range(0, 2047)) - 1024;
    else begin
      s.exp  = int'($urandom_range(0, 20)) - 10;
      s.zero = 1'($urandom);
      s.inf  = 1'($urandom);
      s.nan  = 1'($urandom);
    end
    return s;
  endfunction

  // Monitor: pops the scoreboard on each output transfer; checks hold under stall
  initial begin : monitor
    exp_t             e;
    bit               stall;
    logic [31:0]      h_res;
    logic [4:0]       h_flg;
    logic [TAG_W-1:0] h_tag;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (o_valid !== 1'b1 || o_result !== h_res || o_flags !== h_flg || o_tag !== h_tag) begin
            errors++;
            $display("FAIL stall_hold: got v=%b %h/%b/%0d, expected v=1 %h/%b/%0d",
                     o_valid, o_result, o_flags, o_tag, h_res, h_flg, h_tag);
          end
        end
        if (o_valid && o_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tag %0d result %h, expected none", o_tag, o_result);
          end else begin
            e = sb.pop_front();
            checks++;
            if (o_result !== e.res || o_flags !== e.flg || o_tag !== e.tag) begin
              errors++;
              $display("FAIL output tag=%0d: got %h flags %b tag %0d, expected %h flags %b tag %0d",
                       e.tag, o_result, o_flags, o_tag, e.res, e.flg, e.tag);
            end
          end
        end
        stall = o_valid && !o_ready;
        h_res = o_result;
        h_flg = o_flags;
        h_tag = o_tag;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    i_valid = 1'b0; i_tag = '0; i_sign = 1'b0; i_exp = '0; i_frac = '0;
    i_is_zero = 1'b0; i_is_inf = 1'b0; i_is_nan = 1'b0; i_invalid = 1'b0;
    rm = 1'b0; dn = 1'b0; o_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_result", o_result, 32'd0);
    chk("reset_o_flags", 32'(o_flags), 32'd0);
    chk("reset_o_tag", 32'(o_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_i_ready", 32'(i_ready), 32'd1);

    // Latency: first result appears exactly two edges after acceptance
    send(mk(1'b0, 0, 25'd0, 1'b0, 1'b0), 1'b0, 32'h3F800000, 5'b00000);
    @(negedge clk);
    chk("latency_c1_o_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_c2_o_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1;

    // Directed corner vectors with hand-derived expectations
    send(mk(1'b0, 0, {23'h000001, 2'b10}, 1'b0, 1'b0), 1'b0, 32'h3F800002, 5'b00001);
    send(mk(1'b0, 0, {23'h000001, 2'b10}, 1'b1, 1'b0), 1'b0, 32'h3F800001, 5'b00001);
    send(mk(1'b0, 0, {23'h7FFFFF, 2'b10}, 1'b0, 1'b0), 1'b0, 32'h40000000, 5'b00001);
    send(mk(1'b0, 128, 25'd0, 1'b0, 1'b0), 1'b0, 32'h7F800000, 5'b00101);
    send(mk(1'b1, 128, 25'd0, 1'b1, 1'b0), 1'b0, 32'hFF7FFFFF, 5'b00101);
    begin
      stim_t s;
      s = mk(1'b1, 3, 25'h155, 1'b0, 1'b0);
      s.nan = 1'b1; s.inf = 1'b1; s.inv = 1'b1;
      send(s, 1'b0, 32'h7FBFFFFF, 5'b10000);
      s = mk(1'b1, 0, 25'd0, 1'b0, 1'b0);
      s.inf = 1'b1;
      send(s, 1'b0, 32'hFF800000, 5'b00000);
      s = mk(1'b1, 50, 25'h1FFFFFF, 1'b0, 1'b0);
      s.zero = 1'b1; s.inv = 1'b1;
      send(s, 1'b0, 32'h80000000, 5'b10000);
    end
    send(mk(1'b0, -127, 25'd0, 1'b0, 1'b0), 1'b0, 32'h00400000, 5'b00000);
    send(mk(1'b0, -127, 25'd0, 1'b0, 1'b1), 1'b0, 32'h00000000, 5'b00011);
    send(mk(1'b0, -127, 25'd1, 1'b0, 1'b0), 1'b0, 32'h00400000, 5'b00011);
    send(mk(1'b0, 127, {23'h7FFFFF, 2'b11}, 1'b0, 1'b0), 1'b0, 32'h7F800000, 5'b00101);
    idle(4);

    // Backpressure: two accepted under a stall, then i_ready drops
    o_ready = 1'b0;
    send(mk(1'b0, 1, 25'h0000004, 1'b0, 1'b0), 1'b1, '0, '0);
    send(mk(1'b1, 2, 25'h0000006, 1'b0, 1'b0), 1'b1, '0, '0);
    i_sign = 1'b0; i_exp = 11'd3; i_frac = 25'h0000003; rm = 1'b0; dn = 1'b0;
    i_is_zero = 1'b0; i_is_inf = 1'b0; i_is_nan = 1'b0; i_invalid = 1'b0;
    i_tag = ntag; i_valid = 1'b1;
    @(negedge clk);
    chk("bp_i_ready_low", 32'(i_ready), 32'd0);
    chk("bp_o_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_i_ready_still_low", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    o_ready = 1'b1;
    send(mk(1'b0, 3, 25'h0000003, 1'b0, 1'b0), 1'b1, '0, '0);
    send(mk(1'b1, -130, 25'h1ABCDEF, 1'b0, 1'b0), 1'b1, '0, '0);
    idle(5);

    // Asynchronous reset with two results in flight
    o_ready = 1'b0;
    send(mk(1'b0, 5, 25'h0000100, 1'b0, 1'b0), 1'b1, '0, '0);
    send(mk(1'b0, 6, 25'h0000200, 1'b0, 1'b0), 1'b1, '0, '0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_o_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_o_result", o_result, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    o_ready = 1'b1;
    idle(8);
    chk("rst_mid_i_ready", 32'(i_ready), 32'd1);

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 400; t++) begin
      send(rand_stim(), 1'b1, '0, '0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_ready = 1'b0;
    o_ready = 1'b1;
    idle(10);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_fround.md
# fpu_fround

Round-and-pack stage of the single-precision FPU datapath. It sits directly downstream of the add/sub unit, and of any other arithmetic unit using the same internal format. It takes the unpacked result `{sign, exp, frac, is_zero/inf/nan}` and produces an IEEE-754 binary32 word plus exception flags. It handles SH-4 FPSCR rounding (RN/RZ) and denormal flush (DN) through a 2-stage valid/ready pipeline.

## Interface
Parameters:
- `TAG_W`, default 5: tag width, passed through unchanged.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rm`  in  1  rounding mode: 0 = round-to-nearest-even, 1 = round-to-zero. Sampled with each accepted input.
- `dn`  in  1  1 = flush denormal results to zero. Sampled with each accepted input.
- `i_valid`  in  1  input valid.
- `i_ready`  out  1  stage can accept an input this cycle.
- `i_tag`  in  TAG_W  operation tag.
- `i_sign`  in  1  result sign.
- `i_exp`  in  11  signed, unbiased exponent. Value = 1.frac[24:2] × 2^exp.
- `i_frac`  in  25  `[24:2]` mantissa (hidden 1 dropped), `[1]` guard bit, `[0]` sticky bit.
- `i_is_zero`, `i_is_inf`, `i_is_nan`  in  1 each  special-value classes.
- `i_invalid`  in  1  invalid-operation flag from upstream; passed through.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  consumer accepts the result.
- `o_tag`  out  TAG_W  tag.
- `o_result`  out  32  packed binary32 word.
- `o_flags`  out  5  `{V, Z, O, U, I}` in FPSCR cause order. Z is always 0.

## Operation
- Special cases, in priority order:
  - nan → 0x7FBFFFFF (SH-4 default qNaN).
  - inf → `{sign, 0x7F800000}`.
  - zero → `{sign, 31'h0}`.
  - All special cases set no O/U/I flags. V = `i_invalid` in every case.
- Biased exponent: `be = i_exp + 127`, computed with 12-bit signed arithmetic.
- Normal path (1 ≤ be ≤ 254):
  - L = frac[2], G = frac[1], S = frac[0].
  - RN: round_up = G & (S | L). RZ: round_up = 0.
  - Mantissa is 24 bits including the hidden bit. A carry out of the increment gives `be + 1` and mantissa 0.
  - I = G | S.
- Overflow (be ≥ 255, before or after rounding):
  - RN → `{sign, 0x7F800000}`.
  - RZ → `{sign, 0x7F7FFFFF}`.
  - Set O and I.
- Tiny (be ≤ 0), dn = 1:
  - Result is `{sign, 31'h0}`.
  - Set U and I.
- Tiny (be ≤ 0), dn = 0:
  - Right-shift `{1, frac[24:2], G}` by `1 − be`. Shift amounts ≥ 26 are saturated. All bits shifted out are ORed into sticky together with S.
  - Round per `rm`. Exponent field = 0, or 1 if rounding carries into the hidden bit.
  - U = I = (any bit lost). An exact tiny result sets neither U nor I.

## Timing
- Two pipeline registers: S1 (exponent bias, denormal shift, round decision) and S2 (increment, overflow check, pack, flags).
- Latency: 2 cycles from input acceptance to `o_valid` when there is no backpressure. Throughput is 1 per cycle.
- Input transfer happens on `i_valid & i_ready`. Output transfer happens on `o_valid & o_ready`.
- S2 loads when it is empty or its result is being consumed. S1 loads when it is empty or advancing into S2.
- `i_ready = !s1_valid | s1_advance`. This path is combinational from `o_ready`.
- While `o_valid & !o_ready`, all outputs hold stable.
- Two accepted results are held under a stall. `i_ready` drops the cycle after the second one is accepted.
- Reset values: `o_valid` = 0, `o_result` = 0, `o_flags` = 0, `o_tag` = 0, and both stage valid bits = 0. `i_ready` = 1 after reset.
- Asserting `rst_n` low mid-operation discards in-flight results asynchronously. No output fires for them.
- `rm`/`dn` changing while data is in flight does not affect that data; they are captured into S1.

## Structure
- Shared FPU package/defines (`defines.v`) holds:
  - `FP32_QNAN` = 0x7FBFFFFF, `FP32_BIAS` = 127, `FP32_MAXFIN` = 0x7F7FFFFF.
  - Flag bit indices V/Z/O/U/I.
  - RM encodings.
- Sub-module: reuse the existing `fpu_rsh` residual-collecting right shifter (WIDTH 25, SWIDTH 12) for the denormal shift.
- One `always @(posedge clk or negedge rst_n)` block per pipeline stage.

## Test plan
- sign 0, exp 0, frac 0, rm = 0 → 0x3F800000. Flags 0. `o_valid` exactly 2 cycles after acceptance.
- Tie-to-even, exp 0, frac = `{23'h000001, 2'b10}`:
  - rm = 0 → 0x3F800002, I = 1.
  - rm = 1 → 0x3F800001, I = 1.
- Mantissa carry: exp 0, frac = `{23'h7FFFFF, 2'b10}`, rm = 0 → 0x40000000, I = 1.
- Overflow: exp 128, frac 0:
  - rm = 0 → 0x7F800000, flags O | I.
  - rm = 1 → 0x7F7FFFFF, flags O | I.
  - NaN input → 0x7FBFFFFF with `i_invalid` propagated to V.
- Tiny: exp −127, frac 0:
  - dn = 0 → 0x00400000, flags 0.
  - dn = 1 → 0x00000000, flags U | I.
- Backpressure: send 4 back-to-back inputs with `o_ready` low for 3 cycles.
  - Required: `i_ready` low after 2 inputs accepted; outputs stable during the stall; all 4 results delivered in order with correct tags.
  - Then pulse `rst_n` low with 2 results in flight → `o_valid` = 0 immediately, no stale output afterward.
